mcp47feb_dac_seq: RTL

Multi-channel DAC update sequencer for the MCP47FEB I2C DAC. Sits between the control FSM on clk100 and the existing `i2c_master`, driving its cmd/data streaming handshakes. Queues per-channel write requests, issues one 3-byte register write per channel, and retries on missed ACK. Replaces hand-coded per-design DAC write sequences with a reusable, parametrised block.

---
 rtl/mcp47feb_dac_seq.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/mcp47feb_dac_seq.sv
// MCP47FEB multi-channel DAC write sequencer driving i2c_master's cmd/data streams.
// Build macro DAC_AUTO_REFRESH_EN adds a periodic rewrite of every channel.
module mcp47feb_dac_seq #(
  parameter int         NUM_CH         = 2,
  parameter int         DATA_W         = 12,
  parameter logic [6:0] DEV_ADDR       = 7'h60,
  parameter int         STARTUP_CYCLES = 100000,
  parameter int         MAX_RETRY      = 3,
  parameter int         REFRESH_CYCLES = 10000000
) (
  input  logic                     clk100,
  input  logic                     rst_p,
  input  logic                     upd_req,
  input  logic [NUM_CH-1:0]        upd_mask,
  input  logic [NUM_CH*DATA_W-1:0] ch_value,
  output logic                     ready,
  output logic                     upd_done,
  output logic [NUM_CH-1:0]        err_mask,
  output logic [6:0]               cmd_address,
  output logic                     cmd_start,
  output logic                     cmd_write_multiple,
  output logic                     cmd_stop,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [7:0]               data_in,
  output logic                     data_in_valid,
  output logic                     data_in_last,
  input  logic                     data_in_ready,
  input  logic                     i2c_busy,
  input  logic                     missed_ack
);

  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int RW  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  if (NUM_CH < 1 || NUM_CH > 8 || DATA_W < 8 || DATA_W > 16 || REFRESH_CYCLES < 1)
    $error("mcp47feb_dac_seq: parameter out of range");

  typedef enum logic [2:0] {
    ST_STARTUP, ST_IDLE, ST_CMD, ST_B0, ST_B1, ST_B2, ST_WAIT, ST_NEXT
  } state_t;

  state_t            state, state_nxt;
  logic [31:0]       startup_cnt;
  logic [NUM_CH-1:0] pending, pending_nxt, req_bits, err_set, err_clr;
  logic [CHW-1:0]    ch, sel;
  logic [RW-1:0]     retries;
  logic              nack, nack_eff, busy_seen, wait_done, retry_left;
  logic [15:0]       word;
  logic [4:0]        ch5;

  function automatic logic [RW-1:0] sat_inc(input logic [RW-1:0] v);
    return (v == {RW{1'b1}}) ? v : v + RW'(1);
  endfunction

`ifdef DAC_AUTO_REFRESH_EN
  logic [31:0] refresh_cnt;
  logic        refresh;

  always_ff @(posedge clk100 or posedge rst_p) begin
    if (rst_p)        refresh_cnt <= '0;
    else if (refresh) refresh_cnt <= '0;
    else              refresh_cnt <= refresh_cnt + 32'd1;
  end

  assign refresh  = (refresh_cnt >= 32'(REFRESH_CYCLES - 1));
  assign req_bits = (upd_req ? upd_mask : '0) | (refresh ? {NUM_CH{1'b1}} : '0);
`else
  assign req_bits = upd_req ? upd_mask : '0;
`endif

  assign err_clr    = upd_req ? upd_mask : '0;
  assign nack_eff   = nack | missed_ack;
  assign wait_done  = busy_seen && !i2c_busy;
  assign retry_left = (32'(retries) < 32'(MAX_RETRY));
  assign ch5        = 5'(ch);

  // Lowest pending channel wins.
  always_comb begin
    sel = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (pending[i]) sel = CHW'(i);
  end

  // A request landing in NEXT re-sets the bit being cleared.
  always_comb begin
    pending_nxt = pending;
    if (state == ST_NEXT) pending_nxt[ch] = 1'b0;
    pending_nxt = pending_nxt | req_bits;
  end

  always_comb begin
    err_set = '0;
    if (state == ST_WAIT && wait_done && nack_eff && !retry_left) err_set[ch] = 1'b1;
  end

  always_ff @(posedge clk100 or posedge rst_p) begin
    if (rst_p) begin
      state       <= ST_STARTUP;
      startup_cnt <= '0;
      pending     <= '0;
      ch          <= '0;
      retries     <= '0;
      nack        <= 1'b0;
      busy_seen   <= 1'b0;
      err_mask    <= '0;
      upd_done    <= 1'b0;
    end else begin
      state    <= state_nxt;
      pending  <= pending_nxt;
      err_mask <= (err_mask & ~err_clr) | err_set;
      upd_done <= (state == ST_NEXT) && (pending_nxt == '0);
      if (state == ST_STARTUP && startup_cnt < 32'(STARTUP_CYCLES))
        startup_cnt <= startup_cnt + 32'd1;
      if (state == ST_IDLE && |pending) begin
        ch      <= sel;
        retries <= '0;
      end
      if (state == ST_WAIT && wait_done && nack_eff && retry_left)
        retries <= sat_inc(retries);
      // Ack/busy history covers one attempt, from command acceptance through WAIT.
      if (state_nxt == ST_CMD) begin
        nack      <= 1'b0;
        busy_seen <= 1'b0;
      end else if (state inside {ST_CMD, ST_B0, ST_B1, ST_B2, ST_WAIT}) begin
        nack      <= nack | missed_ack;
        busy_seen <= busy_seen | i2c_busy;
      end
    end
  end

  always_ff @(posedge clk100) begin
    if (state == ST_IDLE && |pending)
      word <= 16'(ch_value[sel*DATA_W +: DATA_W]);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_STARTUP: if (startup_cnt >= 32'(STARTUP_CYCLES)) state_nxt = ST_IDLE;
      ST_IDLE:    if (|pending) state_nxt = ST_CMD;
      ST_CMD:     if (cmd_ready) state_nxt = ST_B0;
      ST_B0:      if (data_in_ready) state_nxt = ST_B1;
      ST_B1:      if (data_in_ready) state_nxt = ST_B2;
      ST_B2:      if (data_in_ready) state_nxt = ST_WAIT;
      ST_WAIT:    if (wait_done) state_nxt = (nack_eff && retry_left) ? ST_CMD : ST_NEXT;
      ST_NEXT:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_STARTUP;
    endcase
  end

  always_comb begin
    cmd_valid          = 1'b0;
    cmd_start          = 1'b0;
    cmd_write_multiple = 1'b0;
    cmd_stop           = 1'b0;
    cmd_address        = '0;
    data_in            = '0;
    data_in_valid      = 1'b0;
    data_in_last       = 1'b0;
    case (state)
      ST_CMD: begin
        cmd_valid          = 1'b1;
        cmd_start          = 1'b1;
        cmd_write_multiple = 1'b1;
        cmd_stop           = 1'b1;
        cmd_address        = DEV_ADDR;
      end
      ST_B0: begin
        data_in       = {ch5, 3'b000};
        data_in_valid = 1'b1;
      end
      ST_B1: begin
        data_in       = word[15:8];
        data_in_valid = 1'b1;
      end
      ST_B2: begin
        data_in       = word[7:0];
        data_in_valid = 1'b1;
        data_in_last  = 1'b1;
      end
      default: ;
    endcase
  end

  assign ready = (state != ST_STARTUP) && (pending == '0);

endmodule
